display_frame_builder: RTL and testbench

DISPLAY_FRAME_BUILDER -- requirements
Module: display_frame_builder

---
 rtl/kim_disp_pkg.sv | 26 ++
 rtl/hex7seg_max.sv | 19 +
 rtl/display_frame_builder.sv | 154 +++++++++++++++
 tb/tb_display_frame_builder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/kim_disp_pkg.sv
// ============================================================================
// kim_disp_pkg
// Shared types and constants for the display frame builder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package kim_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENCODE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // MAX7219 no-decode segment order: bit6 A ... bit0 G (DP added by caller)
  localparam logic [6:0] c_seg_table [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  localparam logic [7:0] c_blank_code = 8'h00;

endpackage

`default_nettype wire

// File: rtl/hex7seg_max.sv
// ============================================================================
// hex7seg_max
// Combinational hex nibble to 7-segment code lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex7seg_max
  import kim_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = c_seg_table[nibble];

endmodule

`default_nettype wire

// File: rtl/display_frame_builder.sv
// ============================================================================
// display_frame_builder
// Builds 8-digit MAX7219 segment frames from a hex value on a periodic tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_frame_builder
  import kim_disp_pkg::*;
#(
  parameter int UPDATE_DIV    = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value_in,
  input  logic [7:0]  digit_en,
  input  logic        hold,
  input  logic        force_req,   // "force" is a reserved word in SystemVerilog
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [63:0] frame_data,
  output logic        busy
);

  localparam logic [15:0] c_tick_max = 16'(UPDATE_DIV - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_tick_cnt;
  logic [2:0]  r_digit;
  logic [31:0] r_snap_value;
  logic [7:0]  r_snap_en;
  logic [31:0] r_last_value;
  logic [7:0]  r_last_en;
  logic        r_force_pend;
  logic        r_sent;

  logic        w_tick;
  logic        w_changed;
  logic        w_launch;
  logic        w_encoding;
  logic        w_transfer;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg;
  logic [7:0]  w_nonzero;
  logic        w_blank;
  logic [7:0]  w_digit_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= 16'd0;
    end else if (w_tick) begin
      r_tick_cnt <= 16'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign w_tick    = (r_tick_cnt == c_tick_max);
  assign w_changed = (value_in != r_last_value) || (digit_en != r_last_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !hold && (w_changed || r_force_pend || !r_sent)) begin
          w_next_state = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (r_digit == 3'd7) begin
          w_next_state = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (frame_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != ST_IDLE);
    frame_valid = (r_state == ST_PRESENT);
    w_launch    = (r_state == ST_IDLE) && (w_next_state == ST_ENCODE);
    w_encoding  = (r_state == ST_ENCODE);
    w_transfer  = (r_state == ST_PRESENT) && frame_ready;
  end

  // Digit k is blanked when no enabled non-zero nibble sits at position k or above
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_nonzero[i] = r_snap_en[i] && (r_snap_value[4*i +: 4] != 4'h0);
    end
  end

  assign w_nibble = r_snap_value[{r_digit, 2'b00} +: 4];
  assign w_blank  = BLANK_LEADING && (r_digit != 3'd0) && ((w_nonzero >> r_digit) == 8'h00);

  hex7seg_max u_hex7seg (
    .nibble (w_nibble),
    .seg    (w_seg)
  );

  assign w_digit_code = (!r_snap_en[r_digit] || w_blank) ? c_blank_code : {1'b0, w_seg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit      <= 3'd0;
      r_snap_value <= 32'd0;
      r_snap_en    <= 8'd0;
      r_last_value <= 32'd0;
      r_last_en    <= 8'd0;
      r_force_pend <= 1'b0;
      r_sent       <= 1'b0;
      frame_data   <= 64'd0;
    end else begin
      if (w_launch) begin
        r_snap_value <= value_in;
        r_snap_en    <= digit_en;
        r_digit      <= 3'd0;
      end
      if (w_encoding) begin
        frame_data[{r_digit, 3'b000} +: 8] <= w_digit_code;
        r_digit                            <= r_digit + 3'd1;
      end
      if (w_transfer) begin
        r_last_value <= r_snap_value;
        r_last_en    <= r_snap_en;
        r_sent       <= 1'b1;
      end
      // A new force on the transfer edge is a fresh request and survives the clear
      if (force_req) begin
        r_force_pend <= 1'b1;
      end else if (w_transfer) begin
        r_force_pend <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_frame_builder.sv
// ============================================================================
// tb_display_frame_builder
// Directed and randomized checks of display_frame_builder against a frame-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_frame_builder;

  localparam int DIV = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] value_in = 32'd0;
  logic [7:0]  digit_en = 8'd0;
  logic        hold = 1'b0;
  logic        force_req = 1'b0;
  logic        frame_ready = 1'b0;
  logic        frame_valid, busy, frame_valid_nb, busy_nb;
  logic [63:0] frame_data, frame_data_nb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  display_frame_builder #(.UPDATE_DIV(DIV), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .digit_en(digit_en),
    .hold(hold), .force_req(force_req), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_data(frame_data), .busy(busy)
  );

  display_frame_builder #(.UPDATE_DIV(DIV), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .digit_en(digit_en),
    .hold(hold), .force_req(force_req), .frame_ready(frame_ready),
    .frame_valid(frame_valid_nb), .frame_data(frame_data_nb), .busy(busy_nb)
  );

  logic [6:0] seg_ref [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Frame-level reference state
  int          cyc = 0;
  int          m_cnt = 0;
  bit          m_busy = 0;
  int          m_launch = 0;
  bit          m_pend = 0;
  bit          m_sent = 0;
  int          m_frames = 0;
  int          dut_frames = 0;
  logic [31:0] m_snap_v = '0, m_last_v = '0;
  logic [7:0]  m_snap_e = '0, m_last_e = '0;
  logic [63:0] m_frame = '0, m_frame_nb = '0, last_actual = '0;

  function automatic logic [63:0] ref_frame(input logic [31:0] v, input logic [7:0] en, input bit blank);
    int top = -1;
    logic [63:0] f = '0;
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) if (en[i] && v[4*i +: 4] != 4'h0) top = i;
    for (int k = 0; k < 8; k++) begin
      nib = v[4*k +: 4];
      if (en[k] && !(blank && k > top && k != 0)) f[8*k +: 8] = {1'b0, seg_ref[nib]};
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, advance the model, then move to 1 time unit after the next edge
  task automatic step();
    bit exp_valid, tick_now;
    exp_valid = m_busy && (cyc >= m_launch + 9);
    tick_now  = (m_cnt == DIV - 1);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("valid", 64'(frame_valid), 64'(exp_valid));
    chk("valid_nb", 64'(frame_valid_nb), 64'(exp_valid));
    if (exp_valid) begin
      chk("data", frame_data, m_frame);
      chk("data_nb", frame_data_nb, m_frame_nb);
    end
    if (frame_valid === 1'b1 && frame_ready) dut_frames++;
    if (exp_valid && frame_ready) begin
      m_busy = 0; m_last_v = m_snap_v; m_last_e = m_snap_e;
      m_sent = 1; m_pend = 0; m_frames++; last_actual = frame_data;
    end else if (!m_busy && tick_now && !hold &&
                 ((value_in != m_last_v) || (digit_en != m_last_e) || m_pend || !m_sent)) begin
      m_busy = 1; m_launch = cyc; m_snap_v = value_in; m_snap_e = digit_en;
      m_frame = ref_frame(value_in, digit_en, 1'b1);
      m_frame_nb = ref_frame(value_in, digit_en, 1'b0);
    end
    if (force_req) m_pend = 1;
    m_cnt = tick_now ? 0 : m_cnt + 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_frame(input string tag, input int bound);
    int start = m_frames;
    int n = 0;
    while (m_frames == start && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 64'(m_frames != start), 64'd1);
    chk({tag, "_count"}, 64'(dut_frames), 64'(m_frames));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", frame_data, 64'd0);
    m_busy = 0; m_cnt = 0; m_pend = 0; m_sent = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    int start, n;
    @(posedge clk);
    #1;
    do_reset();

    // Worked example with leading-zero blanking
    value_in = 32'h0000_1C4F; digit_en = 8'h0F; frame_ready = 1'b1;
    run_until_frame("ex1c4f", 2 * DIV + 12);
    chk("ex1c4f_data", last_actual, 64'h0000_0000_304E_3347);

    value_in = 32'h0000_0007;
    run_until_frame("ex7", DIV + 12);
    chk("ex7_data", last_actual, 64'h0000_0000_0000_0070);
    value_in = 32'h0000_0000;
    run_until_frame("ex0", DIV + 12);
    chk("ex0_data", last_actual, 64'h0000_0000_0000_007E);

    // Back-pressure: frame held stable while the input keeps moving
    frame_ready = 1'b0; value_in = 32'h0000_1234; digit_en = 8'hFF;
    n = 0;
    while (!(m_busy && cyc >= m_launch + 9) && n < 2 * DIV + 12) begin step(); n++; end
    for (int i = 0; i < 50; i++) begin
      value_in = $urandom;
      step();
    end
    value_in = 32'h0000_ABCD;
    frame_ready = 1'b1;
    run_until_frame("held", 4);
    chk("held_data", last_actual, ref_frame(32'h0000_1234, 8'hFF, 1'b1));
    run_until_frame("after_held", DIV + 12);
    chk("after_held_data", last_actual, 64'h0000_0000_771F_4E3D);

    // Unchanged value produces no frame; a force produces exactly one
    start = dut_frames;
    run(3 * DIV);
    chk("idle_no_frame", 64'(dut_frames - start), 64'd0);
    force_req = 1'b1; step(); force_req = 1'b0;
    start = dut_frames;
    run(2 * DIV);
    chk("force_one_frame", 64'(dut_frames - start), 64'd1);

    // Hold blocks capture, but not a frame already in flight
    hold = 1'b1; value_in = 32'h00C0_FFEE;
    start = dut_frames;
    run(2 * DIV);
    chk("hold_no_frame", 64'(dut_frames - start), 64'd0);
    hold = 1'b0;
    run_until_frame("hold_release", DIV + 12);
    value_in = 32'h0000_0042; digit_en = 8'h3C;
    n = 0;
    while (!m_busy && n < DIV + 2) begin step(); n++; end
    hold = 1'b1;
    run_until_frame("hold_inflight", 12);
    hold = 1'b0;

    // Reset mid-encode aborts; first tick afterwards sends regardless of value
    value_in = 32'h8765_4321; digit_en = 8'hFF;
    n = 0;
    while (!(m_busy && cyc == m_launch + 4) && n < DIV + 8) begin step(); n++; end
    start = dut_frames;
    do_reset();
    step();
    chk("abort_no_transfer", 64'(dut_frames - start), 64'd0);
    run_until_frame("post_reset", DIV + 12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) value_in = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 60) == 0) digit_en = 8'($urandom);
      hold        = ($urandom_range(0, 9) == 0);
      force_req   = ($urandom_range(0, 39) == 0);
      frame_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end
    chk("rand_count", 64'(dut_frames), 64'(m_frames));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
